// File: rtl/mig_ui_if.sv
// MIG-style user interface bundle: command channel, write-data channel and read-return channel.
// The initiator (arbiter or bench) takes the master side; the memory model takes the slave side.
interface mig_ui_if #(
  parameter int ADDR_W = 29,
  parameter int DATA_W = 128,
  parameter int MASK_W = 16
);
  logic              app_en;
  logic [2:0]        app_cmd;
  logic [ADDR_W-1:0] app_addr;
  logic              app_rdy;
  logic [DATA_W-1:0] app_wdf_data;
  logic              app_wdf_wren;
  logic              app_wdf_end;
  logic [MASK_W-1:0] app_wdf_mask;
  logic              app_wdf_rdy;
  logic [DATA_W-1:0] app_rd_data;
  logic              app_rd_data_valid;
  logic              app_rd_data_end;

  modport master (
    output app_en, app_cmd, app_addr, app_wdf_data, app_wdf_wren, app_wdf_end, app_wdf_mask,
    input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end
  );

  modport slave (
    input  app_en, app_cmd, app_addr, app_wdf_data, app_wdf_wren, app_wdf_end, app_wdf_mask,
    output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end
  );
endinterface

// File: rtl/mig_ui_responder.sv
// BRAM-backed stand-in for the Series 7 MIG user interface: calibration delay, app_rdy
// throttling, 4-deep write-data FIFO, byte-masked writes and fixed-latency in-order reads.

// One byte lane of the backing RAM; the lane array together forms a byte-enable BRAM.
module mig_ui_bram_lane #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);
  logic [7:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem[raddr_i];
  end
endmodule

module mig_ui_responder #(
  parameter int ADDR_W       = 29,
  parameter int DATA_W       = 128,
  parameter int MASK_W       = 16,
  parameter int DEPTH_LOG2   = 10,
  parameter int CALIB_CYCLES = 64,
  parameter int RD_LATENCY   = 4,
  parameter int RDY_PERIOD   = 0
) (
  input  logic     clk,
  input  logic     reset_n,
  output logic     init_calib_complete,
  output logic     cmd_err,
  mig_ui_if.slave  ui
);
  localparam int CW = $clog2(CALIB_CYCLES + 1);
  localparam int IW = DEPTH_LOG2;
  localparam logic [2:0] CMD_WR = 3'b000;
  localparam logic [2:0] CMD_RD = 3'b001;

  typedef enum logic {WR_IDLE, WR_PEND} wr_state_t;

  logic            calib_q;
  logic [CW-1:0]   cal_cnt_q;
  logic            throttle;
  wr_state_t       wst_q, wst_d;
  logic            retire;
  logic [IW-1:0]   cmd_idx, wr_idx_q;
  logic            cmd_acc, rd_acc, wr_acc, ill_acc, wdf_push;
  logic            cmd_err_q;

  logic [DATA_W-1:0] fdat_q [4];
  logic [MASK_W-1:0] fmsk_q [4];
  logic [1:0]        wptr_q, rptr_q;
  logic [2:0]        fcnt_q;

  logic [MASK_W-1:0][7:0]             ram_rd;
  logic [RD_LATENCY:1]                vld_pipe_q;
  logic [RD_LATENCY-1:1][DATA_W-1:0]  dly_q;

  logic unused_addr;
  assign unused_addr = ^{ui.app_addr[2:0], ui.app_addr[ADDR_W-1:IW+3]};

  // Calibration: done after CALIB_CYCLES edges from reset release, then sticky.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      calib_q   <= 1'b0;
      cal_cnt_q <= '0;
    end else if (!calib_q) begin
      cal_cnt_q <= cal_cnt_q + 1'b1;
      if (cal_cnt_q == CW'(CALIB_CYCLES - 1)) calib_q <= 1'b1;
    end
  end

  generate
    if (RDY_PERIOD > 0) begin : g_thr
      localparam int TW = (RDY_PERIOD > 1) ? $clog2(RDY_PERIOD) : 1;
      logic [TW-1:0] thr_q;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                          thr_q <= '0;
        else if (thr_q == TW'(RDY_PERIOD - 1)) thr_q <= '0;
        else                                   thr_q <= thr_q + 1'b1;
      end
      assign throttle = (thr_q == TW'(RDY_PERIOD - 1));
    end else begin : g_nothr
      assign throttle = 1'b0;
    end
  endgenerate

  assign ui.app_rdy     = calib_q && !throttle && (wst_q == WR_IDLE);
  assign ui.app_wdf_rdy = calib_q && (fcnt_q != 3'd4);

  assign cmd_idx  = ui.app_addr[IW+2:3];
  assign cmd_acc  = ui.app_en && ui.app_rdy;
  assign rd_acc   = cmd_acc && (ui.app_cmd == CMD_RD);
  assign wr_acc   = cmd_acc && (ui.app_cmd == CMD_WR);
  assign ill_acc  = cmd_acc && (ui.app_cmd[2:1] != 2'b00);
  assign wdf_push = ui.app_wdf_wren && ui.app_wdf_rdy;

  // A pending write blocks further commands, so it always retires before the next one is taken.
  always_comb begin
    wst_d  = wst_q;
    retire = 1'b0;
    case (wst_q)
      WR_IDLE: if (wr_acc) wst_d = WR_PEND;
      WR_PEND: if (fcnt_q != 3'd0) begin
        retire = 1'b1;
        wst_d  = WR_IDLE;
      end
      default: wst_d = WR_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wst_q     <= WR_IDLE;
      wr_idx_q  <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      fcnt_q    <= '0;
      cmd_err_q <= 1'b0;
    end else begin
      wst_q <= wst_d;
      if (wr_acc)   wr_idx_q <= cmd_idx;
      if (wdf_push) wptr_q   <= wptr_q + 1'b1;
      if (retire)   rptr_q   <= rptr_q + 1'b1;
      fcnt_q    <= fcnt_q + {2'b00, wdf_push} - {2'b00, retire};
      cmd_err_q <= cmd_err_q | ill_acc | (wdf_push && !ui.app_wdf_end);
    end
  end

  always_ff @(posedge clk) begin
    if (wdf_push) begin
      fdat_q[wptr_q] <= ui.app_wdf_data;
      fmsk_q[wptr_q] <= ui.app_wdf_mask;
    end
  end

  for (genvar b = 0; b < MASK_W; b++) begin : g_lane
    mig_ui_bram_lane #(.AW(IW)) u_lane (
      .clk     (clk),
      .we_i    (retire && !fmsk_q[rptr_q][b]),
      .waddr_i (wr_idx_q),
      .wdata_i (fdat_q[rptr_q][8*b +: 8]),
      .re_i    (rd_acc),
      .raddr_i (cmd_idx),
      .rdata_o (ram_rd[b])
    );
  end

  // RAM read takes one stage; the rest of the latency is a plain delay line beside the valids.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) vld_pipe_q <= '0;
    else          vld_pipe_q <= {vld_pipe_q[RD_LATENCY-1:1], rd_acc};
  end

  always_ff @(posedge clk) begin
    dly_q[1] <= ram_rd;
    for (int k = 2; k < RD_LATENCY; k++) dly_q[k] <= dly_q[k-1];
  end

  assign ui.app_rd_data_valid = vld_pipe_q[RD_LATENCY];
  assign ui.app_rd_data_end   = vld_pipe_q[RD_LATENCY];
  assign ui.app_rd_data       = vld_pipe_q[RD_LATENCY] ? dly_q[RD_LATENCY-1] : '0;
  assign init_calib_complete  = calib_q;
  assign cmd_err              = cmd_err_q;
endmodule

// File: tb/tb_mig_ui_responder.sv
// Directed bench for mig_ui_responder with app_rdy throttling enabled (RDY_PERIOD=3).
module tb_mig_ui_responder;
  logic clk = 1'b0;
  logic reset_n;
  logic init_calib_complete, cmd_err;
  int   n_tot = 0, n_bad = 0;

  mig_ui_if #(.ADDR_W(29), .DATA_W(128), .MASK_W(16)) ui ();

  mig_ui_responder #(
    .ADDR_W(29), .DATA_W(128), .MASK_W(16), .DEPTH_LOG2(10),
    .CALIB_CYCLES(64), .RD_LATENCY(4), .RDY_PERIOD(3)
  ) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .init_calib_complete (init_calib_complete),
    .cmd_err             (cmd_err),
    .ui                  (ui.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rdy(input string tag);
    int n = 0;
    while (!ui.app_rdy && n < 50) begin tick(); n++; end
    if (!ui.app_rdy) chk({tag, " rdy timeout"}, 128'(ui.app_rdy), 128'(1));
  endtask

  task automatic issue_cmd(input logic [2:0] cmd, input logic [28:0] a);
    ui.app_cmd  = cmd;
    ui.app_addr = a;
    ui.app_en   = 1'b1;
    wait_rdy("cmd");
    tick();
    ui.app_en   = 1'b0;
  endtask

  task automatic push_beat(input logic [127:0] d, input logic [15:0] m, input logic e);
    int n = 0;
    ui.app_wdf_data = d;
    ui.app_wdf_mask = m;
    ui.app_wdf_end  = e;
    ui.app_wdf_wren = 1'b1;
    while (!ui.app_wdf_rdy && n < 50) begin tick(); n++; end
    if (!ui.app_wdf_rdy) chk("wdf rdy timeout", 128'(ui.app_wdf_rdy), 128'(1));
    tick();
    ui.app_wdf_wren = 1'b0;
    ui.app_wdf_end  = 1'b1;
  endtask

  // mode 0: data before command, 1: same cycle, 2: command before data
  task automatic do_write(input logic [28:0] a, input logic [127:0] d, input logic [15:0] m,
                          input int mode);
    int n = 0;
    if (mode == 0) begin
      push_beat(d, m, 1'b1);
      issue_cmd(3'b000, a);
      chk("pend blocks rdy", 128'(ui.app_rdy), 128'(0));
    end else if (mode == 1) begin
      while (!(ui.app_rdy && ui.app_wdf_rdy) && n < 50) begin tick(); n++; end
      ui.app_cmd = 3'b000; ui.app_addr = a; ui.app_en = 1'b1;
      ui.app_wdf_data = d; ui.app_wdf_mask = m; ui.app_wdf_wren = 1'b1;
      tick();
      ui.app_en = 1'b0; ui.app_wdf_wren = 1'b0;
      chk("pend blocks rdy", 128'(ui.app_rdy), 128'(0));
    end else begin
      issue_cmd(3'b000, a);
      chk("pend blocks rdy", 128'(ui.app_rdy), 128'(0));
      push_beat(d, m, 1'b1);
    end
    wait_rdy("retire");
  endtask

  task automatic do_read(input logic [28:0] a, input logic [127:0] exp, input string tag);
    int lat = 1;
    issue_cmd(3'b001, a);
    while (!ui.app_rd_data_valid && lat < 20) begin tick(); lat++; end
    chk({tag, " lat"}, 128'(lat), 128'(4));
    chk({tag, " data"}, ui.app_rd_data, exp);
    chk({tag, " end"}, 128'(ui.app_rd_data_end), 128'(1));
  endtask

  task automatic calib_check(input string tag);
    int early = 0, nv = 0;
    for (int i = 1; i <= 64; i++) begin
      tick();
      if (i < 64 && ui.app_rdy) early++;
      if (ui.app_rd_data_valid) nv++;
      if (i == 63) chk({tag, " calib@63"}, 128'(init_calib_complete), 128'(0));
      if (i == 64) chk({tag, " calib@64"}, 128'(init_calib_complete), 128'(1));
    end
    ui.app_en = 1'b0;
    chk({tag, " rdy before calib"}, 128'(early), 128'(0));
    chk({tag, " valids in calib"}, 128'(nv), 128'(0));
  endtask

  logic [127:0] d;
  logic         acc;
  int           issued, lows, nacc;
  int           acc_c[$], vld_c[$];
  logic [127:0] vdat[$];

  initial begin
    reset_n = 1'b0;
    ui.app_en = 1'b0; ui.app_cmd = 3'b000; ui.app_addr = '0;
    ui.app_wdf_data = '0; ui.app_wdf_wren = 1'b0; ui.app_wdf_end = 1'b1; ui.app_wdf_mask = '0;
    tick(); tick(); tick();
    chk("rst outs", 128'({init_calib_complete, ui.app_rdy, ui.app_wdf_rdy,
                          ui.app_rd_data_valid, ui.app_rd_data_end, cmd_err}), 128'(0));
    chk("rst data", ui.app_rd_data, 128'(0));

    // Calibration with app_en held high from release
    reset_n = 1'b1;
    ui.app_en = 1'b1; ui.app_cmd = 3'b001; ui.app_addr = '0;
    calib_check("cal1");

    do_write(29'h10, {8{16'hA5A5}}, 16'h0000, 0);
    do_read(29'h10, {8{16'hA5A5}}, "rd a5");

    do_write(29'h8, {128{1'b1}}, 16'h0000, 1);
    do_write(29'h8, 128'h0, 16'hFFFE, 2);
    do_read(29'h8, {{120{1'b1}}, 8'h00}, "rd mask");

    do_read(29'h10 | (29'h1 << 13), {8{16'hA5A5}}, "rd alias");

    // Fill the write FIFO ahead of any command, then drain it with commands
    for (int j = 0; j < 4; j++) push_beat({8{16'hBE00 + 16'(j)}}, 16'h0000, 1'b1);
    chk("fifo full", 128'(ui.app_wdf_rdy), 128'(0));
    for (int j = 0; j < 4; j++) begin
      issue_cmd(3'b000, 29'h200 + 29'(j * 8));
      wait_rdy("drain");
      if (j == 0) chk("fifo not full", 128'(ui.app_wdf_rdy), 128'(1));
    end
    do_read(29'h200, {8{16'hBE00}}, "rd fifo0");
    do_read(29'h218, {8{16'hBE03}}, "rd fifo3");

    for (int i = 0; i < 12; i++)
      do_write(29'h100 + 29'(i * 8), {4{32'hC0DE0000 + 32'(i)}}, 16'h0000, i % 3);

    // Back-to-back reads under throttling
    issued = 0; lows = 0;
    ui.app_cmd = 3'b001;
    for (int c = 0; c < 80 && vld_c.size() < 12; c++) begin
      if (ui.app_rd_data_valid) begin vld_c.push_back(c); vdat.push_back(ui.app_rd_data); end
      ui.app_en   = (issued < 12);
      ui.app_addr = 29'h100 + 29'(issued * 8);
      acc = ui.app_en && ui.app_rdy;
      if (c < 12 && !ui.app_rdy) lows++;
      if (acc) acc_c.push_back(c);
      tick();
      if (acc) issued++;
    end
    ui.app_en = 1'b0;
    chk("burst accepted", 128'(issued), 128'(12));
    chk("burst rdy lows", 128'(lows), 128'(4));
    chk("burst valids", 128'(vld_c.size()), 128'(12));
    for (int i = 0; i < 12; i++) begin
      if (i < vld_c.size() && i < acc_c.size()) begin
        chk($sformatf("burst lat%0d", i), 128'(vld_c[i] - acc_c[i]), 128'(4));
        chk($sformatf("burst d%0d", i), vdat[i], {4{32'hC0DE0000 + 32'(i)}});
      end
    end

    // Illegal command: accepted, sets sticky error, leaves RAM alone
    chk("err clear", 128'(cmd_err), 128'(0));
    issue_cmd(3'b011, 29'h10);
    chk("err illegal", 128'(cmd_err), 128'(1));
    do_read(29'h10, {8{16'hA5A5}}, "rd after ill");
    chk("err sticky", 128'(cmd_err), 128'(1));

    // Reset with reads in flight
    nacc = 0;
    ui.app_cmd = 3'b001;
    for (int c = 0; c < 20 && nacc < 3; c++) begin
      ui.app_en = 1'b1;
      ui.app_addr = 29'h100 + 29'(nacc * 8);
      acc = ui.app_rdy;
      tick();
      if (acc) nacc++;
    end
    reset_n = 1'b0;
    ui.app_en = 1'b0;
    chk("rst3 accepted", 128'(nacc), 128'(3));
    tick(); tick();
    chk("rst2 outs", 128'({init_calib_complete, ui.app_rdy, ui.app_wdf_rdy,
                           ui.app_rd_data_valid, cmd_err}), 128'(0));
    reset_n = 1'b1;
    calib_check("cal2");
    do_read(29'h8, {{120{1'b1}}, 8'h00}, "rd kept mask");
    do_read(29'h100, {4{32'hC0DE0000}}, "rd kept burst");

    // Beat without wdf_end: still stored, error raised
    chk("err after rst", 128'(cmd_err), 128'(0));
    push_beat({16{8'h3C}}, 16'h00FF, 1'b0);
    chk("err noend", 128'(cmd_err), 128'(1));
    issue_cmd(3'b000, 29'h10);
    wait_rdy("retire noend");
    do_read(29'h10, {{8{8'h3C}}, {4{16'hA5A5}}}, "rd noend");

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
